led_drv: RTL and testbench



---
 rtl/led_drv.sv | 149 ++++++++++++++
 tb/tb_led_drv.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_drv.sv
// led_drv: bus-mapped driver for 8 LEDs, each in off / on / blink / one-shot pulse mode.
// Latency: register writes take effect at the next edge; leds follow mode/phase one cycle later; reads are combinational.
// Backpressure: none; ack mirrors stb, so every access completes in its strobe cycle.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   stb, we, addr     bus access strobe, write enable, register select (0 = MODE, 1 = PERIOD)
//   data_in/data_out  write data / read data (zero when no read is active)
//   ack               access acknowledge (equals stb)
//   leds              registered active-high LED drive
module led_drv #(
    parameter int TICK_DIV    = 50000,
    parameter int PULSE_TICKS = 100,
    parameter int PERIOD_RST  = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic        addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic [7:0]  leds
);

    localparam int              PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX     = PW'(TICK_DIV - 1);
    localparam logic [7:0]      PULSE_LD    = 8'(PULSE_TICKS);
    localparam logic [15:0]     PERIOD_INIT = 16'(PERIOD_RST);

    localparam logic [1:0] M_OFF   = 2'b00;
    localparam logic [1:0] M_ON    = 2'b01;
    localparam logic [1:0] M_BLINK = 2'b10;
    localparam logic [1:0] M_PULSE = 2'b11;

    logic [PW-1:0]     pre_q, pre_d;
    logic [15:0]       mode_q, mode_d;
    logic [15:0]       period_q, period_d;
    logic [15:0]       bcnt_q, bcnt_d;
    logic              phase_q, phase_d;
    logic [7:0][7:0]   pcnt_q, pcnt_d;
    logic [7:0]        leds_q, leds_d;

    logic              tick;
    logic              wr_mode;
    logic              wr_period;
    logic [15:0]       period_eff;

    assign tick      = (pre_q == PRE_MAX);
    assign wr_mode   = stb & we & ~addr;
    assign wr_period = stb & we & addr;

    // Prescaler: free-running, never disturbed by bus writes.
    always_comb begin
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    // Blink timebase. A zero period behaves as one tick per half-period.
    // bcnt never exceeds period-1 (a PERIOD write clears it), so >= is the
    // same as == here but stays safe against any stale count.
    always_comb begin
        period_eff = (period_q == 16'd0) ? 16'd1 : period_q;
        period_d   = period_q;
        bcnt_d     = bcnt_q;
        phase_d    = phase_q;
        if (tick) begin
            if (bcnt_q >= period_eff - 16'd1) begin
                bcnt_d  = 16'd0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 16'd1;
            end
        end
        // A PERIOD write restarts the blink cycle and overrides a same-cycle tick.
        if (wr_period) begin
            period_d = data_in[15:0];
            bcnt_d   = 16'd0;
            phase_d  = 1'b1;
        end
    end

    // Pulse countdown and mode register. An expiring pulse drops its field to
    // off; a MODE write in the same cycle replaces every field and (re)loads
    // the counter of each field it sets to pulse.
    always_comb begin
        mode_d = mode_q;
        pcnt_d = pcnt_q;
        for (int i = 0; i < 8; i++) begin
            if (tick && (mode_q[2*i +: 2] == M_PULSE) && (pcnt_q[i] != 8'd0)) begin
                pcnt_d[i] = pcnt_q[i] - 8'd1;
                if (pcnt_q[i] == 8'd1) begin
                    mode_d[2*i +: 2] = M_OFF;
                end
            end
        end
        if (wr_mode) begin
            mode_d = data_in[15:0];
            for (int i = 0; i < 8; i++) begin
                if (data_in[2*i +: 2] == M_PULSE) begin
                    pcnt_d[i] = PULSE_LD;
                end
            end
        end
    end

    always_comb begin
        leds_d = '0;
        for (int i = 0; i < 8; i++) begin
            case (mode_q[2*i +: 2])
                M_OFF:   leds_d[i] = 1'b0;
                M_ON:    leds_d[i] = 1'b1;
                M_BLINK: leds_d[i] = phase_q;
                default: leds_d[i] = (pcnt_q[i] != 8'd0);
            endcase
        end
    end

    always_comb begin
        data_out = 32'd0;
        if (stb && !we) begin
            data_out = addr ? {16'd0, period_q} : {8'd0, leds_q, mode_q};
        end
    end

    assign ack  = stb;
    assign leds = leds_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q    <= '0;
            mode_q   <= 16'd0;
            period_q <= PERIOD_INIT;
            bcnt_q   <= 16'd0;
            phase_q  <= 1'b1;
            pcnt_q   <= '0;
            leds_q   <= 8'd0;
        end else begin
            pre_q    <= pre_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
            pcnt_q   <= pcnt_d;
            leds_q   <= leds_d;
        end
    end

endmodule

// File: tb/tb_led_drv.sv
// tb_led_drv: directed vector table, hand-written corner sequences and random bus traffic for led_drv.
// The reference model tracks ticks since reset / since PERIOD write and pulse expiry tick numbers.
// Outputs are sampled 1 time unit after the falling edge; inputs change on the falling edge.
module tb_led_drv;

    localparam int TD = 4;
    localparam int PT = 5;
    localparam int PR = 500;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        we;
    logic        addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;
    logic [7:0]  leds;

    always #5 clk = ~clk;

    led_drv #(.TICK_DIV(TD), .PULSE_TICKS(PT), .PERIOD_RST(PR)) dut (
        .clk      (clk),
        .rst      (rst),
        .stb      (stb),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .leds     (leds)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [15:0] m_mode;
    logic [15:0] m_period;
    int          m_cyc;      // cycles since reset (prescaler position)
    int          m_ntk;      // ticks since reset or last PERIOD write
    int          m_gt;       // ticks since reset
    int          m_exp [8];  // tick number at which each pulse ends
    logic [7:0]  m_leds;

    typedef struct {
        logic        s;
        logic        w;
        logic        a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic [7:0]  exp_leds;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int val, input int lo, input int hi);
        n_tests++;
        if (val < lo || val > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    function automatic logic m_phase();
        int eff;
        eff = (m_period == 16'd0) ? 1 : int'(m_period);
        return ((m_ntk / eff) % 2) == 0;
    endfunction

    function automatic logic [7:0] m_led_next();
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            case (m_mode[2*i +: 2])
                2'd0:    r[i] = 1'b0;
                2'd1:    r[i] = 1'b1;
                2'd2:    r[i] = m_phase();
                default: r[i] = (m_gt < m_exp[i]);
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] m_rdata();
        if (stb && !we) return addr ? {16'd0, m_period} : {8'd0, m_leds, m_mode};
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_mode   = 16'd0;
        m_period = 16'(PR);
        m_cyc    = 0;
        m_ntk    = 0;
        m_gt     = 0;
        m_leds   = 8'd0;
        for (int i = 0; i < 8; i++) m_exp[i] = 0;
    endtask

    task automatic apply(input logic s, input logic w, input logic a, input logic [31:0] d);
        stb = s; we = w; addr = a; data_in = d;
        #1;
    endtask

    task automatic check_model();
        chk("leds", 32'(leds), 32'(m_leds));
        chk("ack", 32'(ack), 32'(stb));
        chk("rdata", data_out, m_rdata());
    endtask

    // Step the model across the coming edge using the inputs now applied, then move to the next sample point.
    task automatic advance();
        logic       tk;
        logic [7:0] nl;
        int         gt_new;
        tk     = (m_cyc % TD) == TD - 1;
        nl     = m_led_next();
        gt_new = m_gt + (tk ? 1 : 0);
        if (tk) begin
            m_ntk++;
            for (int i = 0; i < 8; i++)
                if (m_mode[2*i +: 2] == 2'd3 && gt_new == m_exp[i]) m_mode[2*i +: 2] = 2'd0;
        end
        if (stb && we && addr) begin
            m_period = data_in[15:0];
            m_ntk    = 0;
        end
        if (stb && we && !addr) begin
            m_mode = data_in[15:0];
            for (int i = 0; i < 8; i++)
                if (m_mode[2*i +: 2] == 2'd3) m_exp[i] = gt_new + PT;
        end
        m_gt   = gt_new;
        m_cyc++;
        m_leds = nl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc(input logic s, input logic w, input logic a, input logic [31:0] d);
        apply(s, w, a, d);
        check_model();
        advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stb = 1'b0; we = 1'b0; addr = 1'b0; data_in = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Sample leds[bit] over n idle cycles and check spacing of toggles (ignoring the first two samples).
    task automatic blink_run(input string name, input int n, input int half);
        logic prev;
        int   last;
        int   ntog;
        last = -1;
        ntog = 0;
        prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            apply(1'b0, 1'b0, 1'b0, 32'd0);
            check_model();
            if (i == 1) chk({name, "_start"}, 32'(leds[1]), 32'd1);
            if (i >= 2 && leds[1] != prev) begin
                if (last >= 0) chk({name, "_half"}, 32'(i - last), 32'(half));
                last = i;
                ntog++;
            end
            prev = leds[1];
            advance();
        end
        chk_range({name, "_toggles"}, ntog, 3, n);
    endtask

    task automatic count_high(input string name, input int n);
        int hi;
        hi = 0;
        for (int i = 0; i < n; i++) begin
            apply(1'b0, 1'b0, 1'b0, 32'd0);
            check_model();
            if (leds[7]) hi++;
            advance();
        end
        chk_range(name, hi, PT * TD - 3, PT * TD + 3);
    endtask

    initial begin
        logic        s, w, a;
        logic [31:0] d;
        int          budget;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_01F4, 8'h00};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 8'h00};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 8'h00};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0003_0005, 8'h03};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_0000, 8'h03};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 8'h03};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 8'h00};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 32'h1234_0007, 32'h0000_0000, 8'h00};
        tbl[9] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0007, 8'h00};

        do_reset();

        // Directed register access table
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_rdata", i), data_out, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_leds", i), 32'(leds), 32'(tbl[i].exp_leds));
            check_model();
            advance();
        end

        // Blink: 3-tick half period (12 clk), then period 0 (every tick, 4 clk)
        cyc(1'b1, 1'b1, 1'b1, 32'd3);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0008);
        blink_run("blink_p3", 100, 3 * TD);
        cyc(1'b1, 1'b1, 1'b1, 32'd0);
        blink_run("blink_p0", 40, TD);

        // One-shot pulse on LED7, then mode readback
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_C000);
        count_high("pulse_len", 40);
        apply(1'b1, 1'b0, 1'b0, 32'd0);
        chk("pulse_mode_clear", 32'(data_out[15:0]), 32'd0);
        check_model();
        advance();

        // Retrigger mid-pulse extends by a full pulse from the rewrite
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_C000);
        idle(10);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_C000);
        count_high("pulse_retrig", 40);

        // MODE write landing in the exact expiry cycle wins
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_C000);
        budget = 60;
        while (!((m_cyc % TD) == TD - 1 && m_gt + 1 == m_exp[7]) && budget > 0) begin
            idle(1);
            budget--;
        end
        chk("expiry_found", 32'(budget > 0), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_4000);
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b0, 1'b0, 32'd0);
            chk("collide_led7", 32'(leds[7]), 32'd1);
            check_model();
            advance();
        end
        apply(1'b1, 1'b0, 1'b0, 32'd0);
        chk("collide_mode", 32'(data_out[15:0]), 32'h0000_4000);
        check_model();
        advance();

        // Reset during active blink and pulse
        cyc(1'b1, 1'b1, 1'b1, 32'd2);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_C008);
        idle(7);
        do_reset();
        apply(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_ack_idle", 32'(ack), 32'd0);
        chk("rst_rdata_idle", data_out, 32'd0);
        advance();
        apply(1'b1, 1'b0, 1'b0, 32'd0);
        chk("rst_mode", data_out, 32'd0);
        advance();
        apply(1'b1, 1'b0, 1'b1, 32'd0);
        chk("rst_period", data_out, 32'h0000_01F4);
        advance();

        // Random bus traffic against the model
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 3) == 0);
            w = 1'($urandom_range(0, 1));
            a = 1'($urandom_range(0, 1));
            d = $urandom;
            if (a) d[15:0] = 16'($urandom_range(0, 4));
            cyc(s, w, a, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
